// File: rtl/fpaddsub_normalize_round_stage_pkg.sv
// Shared constants for the FP add/sub normalize/round back-end.
package fpaddsub_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MAN_W   = FRAC_W + 3;
    localparam int EXP_MAX = 255;
    localparam int EXPS_W  = EXP_W + 2;

    // Positions of the guard/round information in the normalized mantissa.
    localparam int L_IDX = 2;
    localparam int G_IDX = 1;
    localparam int S_IDX = 0;

endpackage

// File: rtl/fpaddsub_normalize_round_stage_if.sv
// Upstream and downstream valid/ready buses of the normalize/round stage.
interface fpaddsub_normalize_round_stage_if #(
    parameter int EXP_W  = fpaddsub_pkg::EXP_W,
    parameter int FRAC_W = fpaddsub_pkg::FRAC_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic [FRAC_W+2:0]       in_mmin;
    logic [4:0]              in_shift;
    logic [EXP_W-1:0]        in_exp;
    logic                    in_sign;

    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic                    out_ovf;
    logic                    out_unf;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_mmin, in_shift, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf
    );

    // The normalize/round stage itself.
    modport slave (
        input  in_valid, in_mmin, in_shift, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf
    );
endinterface

// File: rtl/fpaddsub_normalize_round_stage_round_rne.sv
// Combinational round-to-nearest-even plus overflow/underflow/zero packing.
module fpaddsub_round_rne #(
    parameter int EXP_W  = fpaddsub_pkg::EXP_W,
    parameter int FRAC_W = fpaddsub_pkg::FRAC_W
) (
    input  logic [FRAC_W+2:0]          m,
    input  logic signed [EXP_W+1:0]    e,
    input  logic                       z,
    input  logic                       sign,
    output logic [EXP_W+FRAC_W:0]      result,
    output logic                       ovf,
    output logic                       unf
);
    import fpaddsub_pkg::L_IDX;
    import fpaddsub_pkg::G_IDX;
    import fpaddsub_pkg::S_IDX;

    localparam int EXPS_W = EXP_W + 2;
    localparam logic signed [EXPS_W-1:0] EMAX_S = EXPS_W'((1 << EXP_W) - 1);
    localparam logic signed [EXPS_W-1:0] ZERO_S = '0;

    // Nearest-even: round up above half, or at exactly half when the kept LSB is odd.
    function automatic logic rne_up(input logic l, input logic g, input logic s);
        return g & (s | l);
    endfunction

    logic                     up;
    logic [FRAC_W:0]          frac_sum;
    logic                     carry;
    logic [FRAC_W-1:0]        frac;
    logic signed [EXPS_W-1:0] e_fin;

    // Increment the fraction, renormalize on carry-out, then classify the exponent.
    always_comb begin
        up       = rne_up(m[L_IDX], m[G_IDX], m[S_IDX]);
        frac_sum = {1'b0, m[FRAC_W+1:L_IDX]} + {{FRAC_W{1'b0}}, up};
        carry    = frac_sum[FRAC_W];
        frac     = carry ? '0 : frac_sum[FRAC_W-1:0];
        e_fin    = e + $signed({{(EXPS_W-1){1'b0}}, carry});
        result   = {sign, e_fin[EXP_W-1:0], frac};
        ovf      = 1'b0;
        unf      = 1'b0;
        if (z) begin
            result = '0;
        end else if (e_fin >= EMAX_S) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf    = 1'b1;
        end else if (e_fin <= ZERO_S) begin
            result = {sign, {(EXP_W+FRAC_W){1'b0}}};
            unf    = 1'b1;
        end
    end

endmodule

// File: rtl/fpaddsub_normalize_round_stage.sv
// Two-stage normalize/round back-end of the FP add/sub pipeline with valid/ready flow control.
module fpaddsub_normalize_round_stage #(
    parameter int EXP_W  = fpaddsub_pkg::EXP_W,
    parameter int FRAC_W = fpaddsub_pkg::FRAC_W
) (
    input  logic clk,
    input  logic rst,
    fpaddsub_normalize_round_stage_if.slave bus
);
    localparam int MAN_W  = FRAC_W + 3;
    localparam int EXPS_W = EXP_W + 2;
    localparam logic signed [EXPS_W-1:0] ONE_S = EXPS_W'(1);

    // Finish the normalize shift by the low four Shift bits (bit4 was applied upstream).
    function automatic logic [MAN_W-1:0] fine_shift(input logic [MAN_W-1:0] m,
                                                    input logic [3:0]       sh);
        logic [MAN_W-1:0] t;
        t = m;
        if (sh[3]) t = t << 8;
        if (sh[2]) t = t << 4;
        if (sh[1]) t = t << 2;
        if (sh[0]) t = t << 1;
        return t;
    endfunction

    logic                     r1, r2;
    logic                     vld_p1, vld_p2;
    logic [MAN_W-1:0]         m_p1;
    logic signed [EXPS_W-1:0] e_p1;
    logic                     z_p1;
    logic                     sign_p1;

    logic [MAN_W-1:0]         m_sh;
    logic signed [EXPS_W-1:0] exp_s, sh_s, e_adj;

    logic [EXP_W+FRAC_W:0]    rnd_result, result_p2;
    logic                     rnd_ovf, rnd_unf, ovf_p2, unf_p2;

    // Stage readiness ripples back from the output so a full pipe still streams.
    always_comb begin
        r2 = !vld_p2 | bus.out_ready;
        r1 = !vld_p1 | r2;
    end

    assign bus.in_ready   = r1;
    assign bus.out_valid  = vld_p2;
    assign bus.out_result = result_p2;
    assign bus.out_ovf    = ovf_p2;
    assign bus.out_unf    = unf_p2;

    // Shifted mantissa and exponent adjustment; Shift=0 means the leading one sits at the carry bit.
    always_comb begin
        m_sh  = fine_shift(bus.in_mmin, bus.in_shift[3:0]);
        exp_s = $signed({{(EXPS_W-EXP_W){1'b0}}, bus.in_exp});
        sh_s  = $signed({{(EXPS_W-5){1'b0}}, bus.in_shift});
        e_adj = exp_s + ONE_S - sh_s;
    end

    // ---- stage 1 boundary ----
    // S1 valid: advances whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (r1) begin
            vld_p1 <= bus.in_valid;
        end
    end

    // S1 data: captured only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (r1 && bus.in_valid) begin
            m_p1    <= m_sh;
            e_p1    <= e_adj;
            z_p1    <= (bus.in_mmin == '0);
            sign_p1 <= bus.in_sign;
        end
    end

    fpaddsub_round_rne #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .m      (m_p1),
        .e      (e_p1),
        .z      (z_p1),
        .sign   (sign_p1),
        .result (rnd_result),
        .ovf    (rnd_ovf),
        .unf    (rnd_unf)
    );

    // ---- stage 2 boundary ----
    // S2: takes a rounded result from S1, holds it while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            ovf_p2    <= 1'b0;
            unf_p2    <= 1'b0;
        end else if (r2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2 <= rnd_result;
                ovf_p2    <= rnd_ovf;
                unf_p2    <= rnd_unf;
            end
        end
    end

endmodule

// File: tb/tb_fpaddsub_normalize_round_stage.sv
// Self-checking bench for the FP add/sub normalize/round back-end.
module tb_fpaddsub_normalize_round_stage;
    import fpaddsub_pkg::*;

    typedef struct { logic [25:0] m; logic [4:0] sh; logic [7:0] ex; logic sg; } item_t;
    typedef struct { logic [31:0] r; logic o; logic u; } res_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fpaddsub_normalize_round_stage_if bus ();

    fpaddsub_normalize_round_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level normalize + round-to-nearest-even on integers.
    function automatic res_t ref_model(input item_t it);
        res_t   r;
        longint full, mant, rem;
        int     e;
        r.r = '0; r.o = 1'b0; r.u = 1'b0;
        if (it.m == 26'd0) return r;
        full = (longint'(it.m) << it.sh[3:0]) % (longint'(1) << 26);
        e    = int'(it.ex) + 1 - int'(it.sh);
        mant = full / 4;
        rem  = full % 4;
        if (rem == 3 || (rem == 2 && (mant % 2) == 1)) mant = mant + 1;
        if (mant >= (longint'(1) << 24)) begin
            mant = mant / 2;
            e    = e + 1;
        end
        if (e >= EXP_MAX) begin
            r.r = {it.sg, 8'hFF, 23'h0}; r.o = 1'b1;
        end else if (e <= 0) begin
            r.r = {it.sg, 31'h0}; r.u = 1'b1;
        end else begin
            r.r = {it.sg, 8'(e), 23'(mant)};
        end
        return r;
    endfunction

    function automatic item_t gen_item();
        item_t       it;
        logic [25:0] lead;
        int          p;
        p     = $urandom_range(0, 15);
        lead  = 26'h2000000 >> p;
        it.m  = lead | (26'($urandom) & (lead - 26'd1));
        it.sh = {1'($urandom_range(0, 1)), 4'(p)};
        it.ex = 8'($urandom_range(0, 255));
        it.sg = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
            it.m  = '0;
            it.sh = 5'd26;
        end
        return it;
    endfunction

    task automatic drive(input item_t it, input logic v);
        bus.in_valid = v;
        bus.in_mmin  = it.m;
        bus.in_shift = it.sh;
        bus.in_exp   = it.ex;
        bus.in_sign  = it.sg;
    endtask

    // Push one operand into an empty pipe and wait (bounded) for its result.
    task automatic run_single(input logic [25:0] mm, input logic [4:0] sh, input logic [7:0] ex,
                              input logic sg, output res_t r, output int lat);
        item_t it;
        it.m = mm; it.sh = sh; it.ex = ex; it.sg = sg;
        r.r = '0; r.o = 1'b0; r.u = 1'b0;
        lat = -1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(it, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat = c; r.r = bus.out_result; r.o = bus.out_ovf; r.u = bus.out_unf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        item_t junk;
        junk = gen_item();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(junk, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_in_rst: got %b expected 0", bus.out_valid); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.out_result !== 32'h0 || bus.out_ovf !== 1'b0 || bus.out_unf !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%b/%b expected 00000000/0/0", bus.out_result, bus.out_ovf, bus.out_unf);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_junk_leak: got out_valid %b expected 0", bus.out_valid); end
        end
    endtask

    task automatic test_basic();
        logic [25:0] mm[3] = '{26'h2000000, 26'h1000000, 26'h0000400};
        logic [4:0]  sh[3] = '{5'd0, 5'd1, 5'b11111};
        logic [7:0]  ex[3] = '{8'd127, 8'd127, 8'd140};
        logic [31:0] ex_r[3] = '{32'h40000000, 32'h3F800000, 32'h37000000};
        res_t r; int lat;
        for (int i = 0; i < 3; i++) begin
            run_single(mm[i], sh[i], ex[i], 1'b0, r, lat);
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected 2", i, lat); end
            n_checks++;
            if (r.r !== ex_r[i] || r.o !== 1'b0 || r.u !== 1'b0) begin
                n_fail++; $display("FAIL basic_result[%0d]: got %h/%b/%b expected %h/0/0", i, r.r, r.o, r.u, ex_r[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [25:0] mm[3] = '{26'h2000002, 26'h2000006, 26'h3FFFFFE};
        logic [31:0] ex_r[3] = '{32'h40000000, 32'h40000002, 32'h40800000};
        res_t r; int lat;
        for (int i = 0; i < 3; i++) begin
            run_single(mm[i], 5'd0, 8'd127, 1'b0, r, lat);
            n_checks++;
            if (lat !== 2 || r.r !== ex_r[i] || r.o !== 1'b0 || r.u !== 1'b0) begin
                n_fail++; $display("FAIL round[%0d]: got %h/%b/%b lat %0d expected %h/0/0 lat 2", i, r.r, r.o, r.u, lat, ex_r[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        res_t r; int lat;
        run_single(26'h2000000, 5'd0, 8'd254, 1'b0, r, lat);
        n_checks++;
        if (r.r !== 32'h7F800000 || r.o !== 1'b1 || r.u !== 1'b0 || lat !== 2) begin
            n_fail++; $display("FAIL overflow: got %h/%b/%b expected 7f800000/1/0", r.r, r.o, r.u);
        end
        run_single(26'h0100000, 5'd5, 8'd3, 1'b0, r, lat);
        n_checks++;
        if (r.r !== 32'h00000000 || r.o !== 1'b0 || r.u !== 1'b1 || lat !== 2) begin
            n_fail++; $display("FAIL underflow: got %h/%b/%b expected 00000000/0/1", r.r, r.o, r.u);
        end
        run_single(26'h0, 5'd26, 8'd100, 1'b1, r, lat);
        n_checks++;
        if (r.r !== 32'h00000000 || r.o !== 1'b0 || r.u !== 1'b0 || lat !== 2) begin
            n_fail++; $display("FAIL zero: got %h/%b/%b expected 00000000/0/0", r.r, r.o, r.u);
        end
    endtask

    task automatic test_backpressure();
        item_t       items[4];
        res_t        q[$];
        res_t        e;
        int          sent, got;
        logic        hold_prev;
        logic [31:0] held;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 4; i++) items[i] = gen_item();
            sent = 0; got = 0; hold_prev = 1'b0; held = '0; q.delete();
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(negedge clk);
                bus.out_ready = (ph == 0) ? (cyc >= 4) : (cyc % 2 == 1);
                if (sent < 4) drive(items[sent], 1'b1);
                else bus.in_valid = 1'b0;
                #1;
                if (hold_prev) begin
                    n_checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_result !== held) begin
                        n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", ph, bus.out_valid, bus.out_result, held);
                    end
                end
                hold_prev = bus.out_valid && !bus.out_ready;
                held      = bus.out_result;
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++; $display("FAIL bp_extra[%0d]: got %h expected no output", ph, bus.out_result);
                    end else begin
                        e = q.pop_front();
                        if (bus.out_result !== e.r || bus.out_ovf !== e.o || bus.out_unf !== e.u) begin
                            n_fail++; $display("FAIL bp_order[%0d]: got %h/%b/%b expected %h/%b/%b", ph, bus.out_result, bus.out_ovf, bus.out_unf, e.r, e.o, e.u);
                        end
                    end
                    got++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back(ref_model(items[sent]));
                    sent++;
                end
                if (ph == 0 && cyc == 3) begin
                    n_checks++;
                    if (sent !== 2 || bus.in_ready !== 1'b0) begin
                        n_fail++; $display("FAIL bp_fill: got accepted %0d in_ready %b expected 2 and 0", sent, bus.in_ready);
                    end
                end
            end
            n_checks++;
            if (got !== 4) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected 4", ph, got); end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                n_checks++;
                if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup[%0d]: got out_valid %b expected 0", ph, bus.out_valid); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        item_t a;
        res_t  r, e;
        int    lat;
        bus.out_ready = 1'b0;
        @(negedge clk); drive(gen_item(), 1'b1);
        @(negedge clk); drive(gen_item(), 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_full: got out_valid %b in_ready %b expected 1 and 0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(gen_item(), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset: got %b/%b/%h expected out_valid 0 in_ready 1 result 0", bus.out_valid, bus.in_ready, bus.out_result);
        end
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got out_valid %b expected 0", bus.out_valid); end
        end
        a = gen_item();
        e = ref_model(a);
        run_single(a.m, a.sh, a.ex, a.sg, r, lat);
        n_checks++;
        if (lat !== 2 || r.r !== e.r || r.o !== e.o || r.u !== e.u) begin
            n_fail++; $display("FAIL mid_fresh: got %h/%b/%b lat %0d expected %h/%b/%b lat 2", r.r, r.o, r.u, lat, e.r, e.o, e.u);
        end
    endtask

    task automatic test_random();
        localparam int N = 300;
        item_t cur;
        res_t  q[$];
        res_t  e;
        int    sent, got;
        sent = 0; got = 0; q.delete();
        cur = gen_item();
        for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < N) drive(cur, ($urandom_range(0, 4) != 0));
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: got %h expected no output", bus.out_result);
                end else begin
                    e = q.pop_front();
                    if (bus.out_result !== e.r || bus.out_ovf !== e.o || bus.out_unf !== e.u) begin
                        n_fail++; $display("FAIL rand_result[%0d]: got %h/%b/%b expected %h/%b/%b", got, bus.out_result, bus.out_ovf, bus.out_unf, e.r, e.o, e.u);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model(cur));
                sent++;
                cur = gen_item();
            end
        end
        n_checks++;
        if (got !== N) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", got, N); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mmin   = '0;
        bus.in_shift  = '0;
        bus.in_exp    = '0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_boundaries();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpaddsub_normalize_round_stage.md
Name: fpaddsub_normalize_round_stage

Overview:
- Pipelined back-end of the FP add/sub datapath.
- Consumes the output of the leading-one normalize module: a 26-bit mantissa already coarse-shifted by 16 when Shift[4]=1, plus the 5-bit Shift.
- Finishes the left shift by Shift[3:0], adjusts the exponent, rounds to nearest-even, handles zero/overflow/underflow, and packs an IEEE754 single.
- Two register stages with a valid/ready handshake so the adder pipeline can be back-pressured.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width. Mantissa width MAN_W = FRAC_W+3 = 26 is fixed by the upstream stage.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept this cycle
- in_mmin  in  26  coarse-shifted mantissa (leading one lies within bit25..bit10 after the coarse shift)
- in_shift  in  5  total normalize shift; bit4 already applied upstream
- in_exp  in  8  biased exponent of the larger operand
- in_sign  in  1  result sign
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed {sign, exp, frac}
- out_ovf  out  1  result overflowed to infinity
- out_unf  out  1  result flushed to zero (nonzero input, exponent <= 0)

Behaviour:
- Transfer rules: input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- Stage readiness: r2 = !v2 | out_ready; r1 = !v1 | r2; in_ready = r1, combinational from out_ready and the internal valids.
- Latency: 2 cycles, input transfer to out_valid. Full throughput of 1 result/cycle while out_ready=1.
- S1 register (loads when r1):
  - m1 = in_mmin << in_shift[3:0], done as 8/4/2/1 log stages, zero-filled, 26 bits kept.
  - e1 = signed 10-bit {in_exp} + 1 - in_shift (Shift=0 means the leading one is at bit25, the carry position).
  - z1 = (in_mmin == 0).
  - Sign registered.
- S2 register (loads when r2):
  - Bit fields of m1: L = m1[2], G = m1[1], S = m1[0].
  - Round up iff G & (S | L).
  - frac = m1[24:2] + up. If the increment carries out, frac = 0 and e1 is incremented.
  - Overflow: final e >= 255 -> exp = 255, frac = 0, out_ovf = 1.
  - Underflow: final e <= 0 and !z1 -> result = {sign, 31'b0}, out_unf = 1. No subnormals are produced.
  - Zero: z1 -> result = 32'h00000000 (positive zero), flags 0, regardless of shift/exp.
- Holding: a stage whose valid is set and whose downstream is not ready holds its data unchanged. out_result is stable while out_valid & !out_ready.
- Simultaneous push and pop with full stages is legal; no bubble is inserted.
- Reset: v1, v2, out_valid = 0; out_result = 0; out_ovf = out_unf = 0. In-flight data is discarded. in_ready = 1 in the cycle after rst deasserts.
- Inputs are ignored while rst = 1.
- Upstream encodes an all-zero sum as Shift = 26; this is handled by z1.

Decomposition:
- Package fpaddsub_pkg:
  - EXP_W, FRAC_W, MAN_W, EXP_MAX = 255.
  - Signed exponent width EXPS_W = EXP_W+2.
  - Round-bit index constants: L_IDX = 2, G_IDX = 1, S_IDX = 0.
- Sub-module fpaddsub_round_rne: combinational RNE increment, carry-out exponent bump, and ovf/unf/zero packing, instantiated in S2.
- The shifter stays inline in S1.

Test Plan:
- in_mmin = 26'h2000000, shift = 0, exp = 127, sign = 0 -> result 32'h40000000, flags 0, out_valid exactly 2 cycles after accept.
- in_mmin = 26'h1000000, shift = 1, exp = 127 -> 32'h3F800000. Also in_mmin = 26'h0000400 (pre-shifted), shift = 5'b11111, exp = 140 -> bit10 << 15 = bit25, e = 140+1-31 = 110 -> 32'h37000000.
- Rounding, exp = 127: 26'h2000002 (tie, L=0) -> 32'h40000000; 26'h2000006 (tie, L=1) -> 32'h40000002; 26'h3FFFFFE (carry-out) -> 32'h40800000.
- Boundaries:
  - exp = 254, mmin = 26'h2000000, shift = 0 -> 32'h7F800000, out_ovf = 1.
  - exp = 3, mmin = 26'h0100000, shift = 5 -> e = -1 -> 32'h00000000, out_unf = 1.
  - mmin = 0, shift = 26, sign = 1 -> 32'h00000000, flags 0.
- Backpressure: stream 4 inputs with out_ready = 0 for 4 cycles:
  - 2 accepted, then in_ready = 0.
  - out_result held stable.
  - On release, all 4 emerge in order with no duplicates or drops.
  - Toggling out_ready every cycle gives the same ordering.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> out_valid = 0 the next cycle, no stale result ever emitted. A fresh input then gives the correct result 2 cycles later.
